rf_wb_arbiter: RTL
==================

Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (we/wa/wd) between two writers:
  - A: main pipeline writeback, normal priority winner.
  - B: long-latency unit (mul/div or load refill).
- Grants one writer per cycle with a starvation guard for B.
- Keeps a scoreboard of destination registers with B results outstanding, so issue logic can stall on RAW hazards.
- Sits between the execute/writeback stages and the register file.

Parameters:
- DW, 32, data width of write data.
- AW, 5, register address width (2**AW registers).
- MAX_WAIT, 4, consecutive cycles B may be refused before it is forced to win (1..15).

Ports:
- clk  in  1  clock, all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- a_valid  in  1  writer A request.
- a_ready  out  1  writer A accepted this cycle.
- a_wa  in  AW  writer A destination.
- a_wd  in  DW  writer A data.
- b_valid  in  1  writer B request.
- b_ready  out  1  writer B accepted this cycle.
- b_wa  in  AW  writer B destination.
- b_wd  in  DW  writer B data.
- iss_valid  in  1  B-unit operation issued; mark destination pending.
- iss_rd  in  AW  destination of issued B operation.
- chk_ra1  in  AW  hazard query address 1.
- chk_ra2  in  AW  hazard query address 2.
- chk_busy  out  1  either query address pending (combinational).
- rf_we  out  1  register file write enable (registered).
- rf_wa  out  AW  register file write address (registered).
- rf_wd  out  DW  register file write data (registered).

Behaviour:
- Reset (rstn=0, async):
  - rf_we=0, rf_wa=0, rf_wd=0.
  - All pending bits=0, wait counter=0, state=NORM.
  - a_ready/b_ready are 0 while rstn=0.
- Handshake:
  - A transfer occurs when valid & ready.
  - ready is combinational from the valids and state; it never depends on ready of the other side.
  - Requesters hold valid/address/data stable until accepted.
- FSM, two states:
  - NORM: if a_valid, a_ready=1 and b_ready=0. Otherwise b_ready=b_valid.
  - FORCE_B: b_ready=1 and a_ready=0, regardless of a_valid.
- Wait counter:
  - Increments each cycle with b_valid & !b_ready.
  - Clears on any B accept or when b_valid=0.
  - Counter reaching MAX_WAIT -> next state FORCE_B.
  - FORCE_B -> NORM after the B accept, or immediately if b_valid drops.
  - Counter saturates; it does not wrap.
- Write-port output:
  - Accepted transfer in cycle N -> rf_we=1 with that wa/wd in cycle N+1 (latency 1); the register file writes at edge N+2.
  - No transfer -> rf_we=0, rf_wa/rf_wd hold last value.
- wa==0 from either writer: accepted normally; rf_we stays 0 for that cycle. Register 0 is never written.
- Scoreboard:
  - pending[iss_rd] is set at the edge where iss_valid=1 and iss_rd!=0.
  - pending[b_wa] is cleared at the edge of the B accept.
  - Same-cycle set and clear on the same address: set wins.
  - Re-issue to an already pending register: stays set, with no count.
  - pending[0] is always 0.
- chk_busy = pending[chk_ra1] | pending[chk_ra2]; address 0 is never busy.
  - The pending bit clears at the accept edge. The data reaches the register file one edge later.
  - Without the optional feature, issue logic must hold one extra cycle. Verification checks that chk_busy drops exactly at the accept edge.
- A writes do not touch the scoreboard.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- Enabled: adds ports chk_fwd1/chk_fwd2 (out, 1) and fwd_wd (out, DW).
  - chk_fwdX=1 when rf_we=1 and rf_wa==chk_raX!=0.
  - fwd_wd=rf_wd.
  - Lets the consumer take the in-flight value in the cycle before the register file holds it.
- Disabled: these ports and that logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-transfer: a_valid=1 a_wa=3 a_wd=0x11, deassert rstn between edges -> rf_we=0 immediately, no write to reg 3 after release until a new accept.
- Priority: a_valid and b_valid both held, MAX_WAIT=4:
  - A accepted 4 cycles, then B accepted in cycle 5 (FORCE_B, a_ready=0).
  - rf_we/rf_wa follow one cycle later.
- Scoreboard: iss_valid iss_rd=7, then chk_ra1=7 -> chk_busy=1.
  - B write b_wa=7 accepted -> chk_busy=0 after that edge.
  - rf_wa=7 rf_wd=B data next cycle.
- Set/clear collision: iss_rd=9 and B accept b_wa=9 in same cycle -> pending[9]=1 afterwards, chk_busy=1.
- Zero register: a_wa=0 a_wd=0xFFFFFFFF accepted -> a_ready=1, rf_we stays 0. iss_rd=0 -> chk_busy with chk_ra1=0 stays 0.
- Bypass (RF_WB_BYPASS_EN): A writes wa=5 wd=0xABCD, chk_ra2=5 -> chk_fwd2=1 and fwd_wd=0xABCD in the cycle rf_we=1, 0 the cycle after.

Source files
------------

// File: rtl/rf_wb_arbiter_if.sv
// Bundle of the writer handshakes, scoreboard issue/query and register-file write port.
// With RF_WB_BYPASS_EN defined the in-flight forwarding signals are added.
interface rf_wb_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          a_valid;
  logic          a_ready;
  logic [AW-1:0] a_wa;
  logic [DW-1:0] a_wd;
  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] b_wa;
  logic [DW-1:0] b_wd;
  logic          iss_valid;
  logic [AW-1:0] iss_rd;
  logic [AW-1:0] chk_ra1;
  logic [AW-1:0] chk_ra2;
  logic          chk_busy;
  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
`ifdef RF_WB_BYPASS_EN
  logic          chk_fwd1;
  logic          chk_fwd2;
  logic [DW-1:0] fwd_wd;

  modport master (
    output a_valid, a_wa, a_wd, b_valid, b_wa, b_wd, iss_valid, iss_rd, chk_ra1, chk_ra2,
    input  a_ready, b_ready, chk_busy, rf_we, rf_wa, rf_wd, chk_fwd1, chk_fwd2, fwd_wd
  );
  modport slave (
    input  a_valid, a_wa, a_wd, b_valid, b_wa, b_wd, iss_valid, iss_rd, chk_ra1, chk_ra2,
    output a_ready, b_ready, chk_busy, rf_we, rf_wa, rf_wd, chk_fwd1, chk_fwd2, fwd_wd
  );
`else
  modport master (
    output a_valid, a_wa, a_wd, b_valid, b_wa, b_wd, iss_valid, iss_rd, chk_ra1, chk_ra2,
    input  a_ready, b_ready, chk_busy, rf_we, rf_wa, rf_wd
  );
  modport slave (
    input  a_valid, a_wa, a_wd, b_valid, b_wa, b_wd, iss_valid, iss_rd, chk_ra1, chk_ra2,
    output a_ready, b_ready, chk_busy, rf_we, rf_wa, rf_wd
  );
`endif
endinterface

// File: rtl/rf_wb_arbiter.sv
// Two-writer arbiter for the single register-file write port, with a B starvation guard
// and a pending-destination scoreboard. Optional forwarding outputs under RF_WB_BYPASS_EN.
module rf_wb_arbiter #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rstn,
  rf_wb_arbiter_if.slave    bus
);
  localparam int         NREG     = 1 << AW;
  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  typedef enum logic {NORM = 1'b0, FORCE_B = 1'b1} state_t;

  state_t          state_r;
  logic [3:0]      wait_cnt_r;
  logic [3:0]      wait_cnt_s;
  logic [NREG-1:0] pending_r;
  logic [NREG-1:0] pending_s;
  logic            a_rdy_s;
  logic            b_rdy_s;
  logic            a_xfer_s;
  logic            b_xfer_s;
  logic            wr_en_s;
  logic [AW-1:0]   wr_wa_s;
  logic [DW-1:0]   wr_wd_s;

  // Grant decode: ready depends only on the valids and the arbitration state
  always_comb begin
    a_rdy_s = 1'b0;
    b_rdy_s = 1'b0;
    if (!rstn) begin
      a_rdy_s = 1'b0;
      b_rdy_s = 1'b0;
    end else begin
      case (state_r)
        NORM: begin
          a_rdy_s = bus.a_valid;
          b_rdy_s = bus.b_valid & ~bus.a_valid;
        end
        FORCE_B: begin
          a_rdy_s = 1'b0;
          b_rdy_s = 1'b1;
        end
        default: begin
          a_rdy_s = 1'b0;
          b_rdy_s = 1'b0;
        end
      endcase
    end
  end

  assign bus.a_ready = a_rdy_s;
  assign bus.b_ready = b_rdy_s;
  assign a_xfer_s    = bus.a_valid & a_rdy_s;
  assign b_xfer_s    = bus.b_valid & b_rdy_s;

  // Next wait count, write-port mux and scoreboard update
  always_comb begin
    wait_cnt_s = 4'd0;
    wr_en_s    = 1'b0;
    wr_wa_s    = bus.a_wa;
    wr_wd_s    = bus.a_wd;
    pending_s  = pending_r;
    if (bus.b_valid && !b_rdy_s) begin
      wait_cnt_s = (wait_cnt_r == 4'd15) ? 4'd15 : wait_cnt_r + 4'd1;
    end else begin
      wait_cnt_s = 4'd0;
    end
    if (a_xfer_s) begin
      wr_en_s = (bus.a_wa != {AW{1'b0}});
      wr_wa_s = bus.a_wa;
      wr_wd_s = bus.a_wd;
    end else if (b_xfer_s) begin
      wr_en_s = (bus.b_wa != {AW{1'b0}});
      wr_wa_s = bus.b_wa;
      wr_wd_s = bus.b_wd;
    end else begin
      wr_en_s = 1'b0;
    end
    // Clear first so a same-edge issue to the same register keeps it pending
    if (b_xfer_s) begin
      pending_s[bus.b_wa] = 1'b0;
    end else begin
      pending_s = pending_s;
    end
    if (bus.iss_valid && (bus.iss_rd != {AW{1'b0}})) begin
      pending_s[bus.iss_rd] = 1'b1;
    end else begin
      pending_s = pending_s;
    end
    pending_s[0] = 1'b0;
  end

  // Arbitration FSM, starvation counter and registered write port
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= NORM;
      wait_cnt_r <= 4'd0;
      bus.rf_we  <= 1'b0;
      bus.rf_wa  <= {AW{1'b0}};
      bus.rf_wd  <= {DW{1'b0}};
    end else begin
      wait_cnt_r <= wait_cnt_s;
      case (state_r)
        NORM:    state_r <= (wait_cnt_s >= WAIT_LIM) ? FORCE_B : NORM;
        FORCE_B: state_r <= NORM;
        default: state_r <= NORM;
      endcase
      bus.rf_we <= wr_en_s;
      if (wr_en_s) begin
        bus.rf_wa <= wr_wa_s;
        bus.rf_wd <= wr_wd_s;
      end
    end
  end

  // Pending-destination scoreboard
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending_r <= {NREG{1'b0}};
    end else begin
      pending_r <= pending_s;
    end
  end

  assign bus.chk_busy = pending_r[bus.chk_ra1] | pending_r[bus.chk_ra2];

`ifdef RF_WB_BYPASS_EN
  assign bus.chk_fwd1 = bus.rf_we && (bus.rf_wa == bus.chk_ra1) && (bus.chk_ra1 != {AW{1'b0}});
  assign bus.chk_fwd2 = bus.rf_we && (bus.rf_wa == bus.chk_ra2) && (bus.chk_ra2 != {AW{1'b0}});
  assign bus.fwd_wd   = bus.rf_wd;
`endif
endmodule
